ibex_trace_event_buffer: RTL and testbench
==========================================

IBEX_TRACE_EVENT_BUFFER -- requirements
Module: ibex_trace_event_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, 4..64.
REQ-002 SHALL have parameter TS_W, default 16: timestamp width.
REQ-003 SHALL have port clk  in  1  sole clock; all state on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports fetch_ready  in  1, fetch_valid  in  1: fetch stage ready/valid.
REQ-006 SHALL have ports fetch_pc  in  32, fetch_insn  in  32: fetched PC and instruction.
REQ-007 SHALL have ports idex_executing  in  1, idex_done  in  1, idex_pc  in  32: ID/EX status and PC.
REQ-008 SHALL have ports ev_valid  out  1, ev_ready  in  1: event output handshake.
REQ-009 SHALL have ports ev_type  out  3, ev_ts  out  TS_W, ev_pc  out  32, ev_data  out  32: head event fields.
REQ-010 SHALL have port drop_count  out  16: total events dropped, saturating.

Function
REQ-011 SHALL register history bits fetch_ready_q, fetch_valid_q, idex_executing_q, idex_done_q every cycle; define mult = idex_executing_q && !idex_done_q.
REQ-012 SHALL classify ID/EX per cycle: executing&&done&&mult -> IDEX_MEND(5); executing&&done&&!mult -> IDEX(3); executing&&!done&&!mult -> IDEX_MSTART(4); else none.
REQ-013 SHALL classify fetch per cycle: ready&&valid&&(!ready_q||valid_q) -> IF(0); ready&&valid&&ready_q&&!valid_q -> IF_END(2); ready&&!valid&&(!ready_q||valid_q) -> IF_START(1); else none.
REQ-014 SHALL fill fields: IF/IF_END pc=fetch_pc, data=fetch_insn; IF_START pc=0, data=0; IDEX* pc=idex_pc, data=0; OVF(7) pc=0, data={16'b0, drop_count after update}.
REQ-015 SHALL run a free-running TS_W counter, 0 at reset, +1 per cycle, wrapping to 0; each event takes the counter value of its detection cycle.
REQ-016 SHALL support up to three writes per cycle in order: pending OVF marker, ID/EX event, fetch event.
REQ-017 SHALL compute free slots as DEPTH minus occupancy at cycle start; a slot freed by a same-cycle pop SHALL NOT be reused that cycle.
REQ-018 SHALL write candidates in REQ-016 order while slots remain; each non-fitting ID/EX or fetch event SHALL increment drop_count (saturate at 16'hFFFF) and set ovf_pending.
REQ-019 SHALL write the OVF marker only when ovf_pending is set and at least one slot is free at cycle start, then clear ovf_pending unless a drop occurs in the same cycle.
REQ-020 SHALL present the head entry first-word-fall-through: ev_valid=occupancy!=0; pop on ev_valid&&ev_ready; ev_* stable while ev_valid&&!ev_ready.
REQ-021 SHALL make an event detected in cycle N visible on ev_* no earlier than cycle N+1 (no input-to-output combinational path).
REQ-022 SHALL, when empty with simultaneous push, show ev_valid=1 in the next cycle; ev_ready is ignored while ev_valid=0.
REQ-023 SHALL drive ev_type/ev_ts/ev_pc/ev_data to 0 when ev_valid=0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear: history bits, timestamp, pointers, occupancy, ovf_pending, drop_count; ev_valid=0 and all ev_* =0.
REQ-025 SHALL discard buffered events on mid-operation reset; first classification on the first posedge with rst_n high, using cleared history.
REQ-026 SHALL not require storage-array reset; only valid-qualifying state is reset.

Structure
REQ-027 SHALL place in package ibex_trace_pkg: 3-bit event-type enum (IF, IF_START, IF_END, IDEX, IDEX_MSTART, IDEX_MEND, OVF) and a packed event struct {type, ts, pc, data} parameterised by TS_W via localparam default 16.
REQ-028 SHALL instantiate one sub-module ibex_trace_classify holding history bits and REQ-011..014 logic, outputting up to two event structs with valid bits.

Verification
REQ-029 Single fetch: ready=1,valid=1 from reset, fetch_pc=0x80, insn=0x13 -> IF, pc 0x80, data 0x13, ts 0 at cycle 1.
REQ-030 Multicycle fetch: ready=1,valid=0 for 3 cycles then valid=1, pc=0x84 -> one IF_START then one IF_END pc 0x84, ts difference 3.
REQ-031 Multicycle exec: executing=1,done=0 for 2 cycles then done=1, pc=0x100 -> IDEX_MSTART then IDEX_MEND, both pc 0x100; no IDEX.
REQ-032 Dual event: IDEX and IF same cycle, FIFO empty -> two entries, IDEX first, equal ts.
REQ-033 Overflow: DEPTH=8, ev_ready=0, 10 IF events -> 8 stored, drop_count=2; raise ev_ready -> 8 IF drained, then OVF with data 2.
REQ-034 Reset mid-stream: 5 buffered, assert rst_n low -> ev_valid=0, drop_count=0, ts restarts at 0.

Source files
------------

// File: rtl/ibex_trace_pkg.sv
// Shared trace event types: 3-bit event codes and the packed event record
// handed from the classifier to the event buffer.
package ibex_trace_pkg;

    localparam int TS_W = 16;

    typedef enum logic [2:0] {
        EV_IF          = 3'd0,
        EV_IF_START    = 3'd1,
        EV_IF_END      = 3'd2,
        EV_IDEX        = 3'd3,
        EV_IDEX_MSTART = 3'd4,
        EV_IDEX_MEND   = 3'd5,
        EV_OVF         = 3'd7
    } ev_type_e;

    typedef struct packed {
        ev_type_e        ev_type;
        logic [TS_W-1:0] ts;
        logic [31:0]     pc;
        logic [31:0]     data;
    } trace_ev_t;

endpackage

// File: rtl/ibex_trace_classify.sv
// Per-cycle event detection for the fetch and ID/EX stages, using one cycle
// of handshake history to spot starts and ends of multicycle operations.
module ibex_trace_classify
    import ibex_trace_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_ready,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [31:0] fetch_insn,
    input  logic        idex_executing,
    input  logic        idex_done,
    input  logic [31:0] idex_pc,
    output logic        idex_ev_valid,
    output trace_ev_t   idex_ev,
    output logic        fetch_ev_valid,
    output trace_ev_t   fetch_ev
);

    logic fetch_ready_q, fetch_valid_q, idex_executing_q, idex_done_q;
    logic mult;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_ready_q    <= 1'b0;
            fetch_valid_q    <= 1'b0;
            idex_executing_q <= 1'b0;
            idex_done_q      <= 1'b0;
        end else begin
            fetch_ready_q    <= fetch_ready;
            fetch_valid_q    <= fetch_valid;
            idex_executing_q <= idex_executing;
            idex_done_q      <= idex_done;
        end
    end

    assign mult = idex_executing_q && !idex_done_q;

    // Timestamps are stamped by the buffer; ts is left zero here.
    always_comb begin
        idex_ev_valid = 1'b0;
        idex_ev       = '0;
        idex_ev.pc    = idex_pc;
        if (idex_executing && idex_done) begin
            idex_ev_valid   = 1'b1;
            idex_ev.ev_type = mult ? EV_IDEX_MEND : EV_IDEX;
        end else if (idex_executing && !idex_done && !mult) begin
            idex_ev_valid   = 1'b1;
            idex_ev.ev_type = EV_IDEX_MSTART;
        end
    end

    always_comb begin
        fetch_ev_valid = 1'b0;
        fetch_ev       = '0;
        if (fetch_ready && fetch_valid) begin
            fetch_ev_valid   = 1'b1;
            fetch_ev.ev_type = (fetch_ready_q && !fetch_valid_q) ? EV_IF_END : EV_IF;
            fetch_ev.pc      = fetch_pc;
            fetch_ev.data    = fetch_insn;
        end else if (fetch_ready && !fetch_valid && (!fetch_ready_q || fetch_valid_q)) begin
            fetch_ev_valid   = 1'b1;
            fetch_ev.ev_type = EV_IF_START;
        end
    end

endmodule

// File: rtl/ibex_trace_event_buffer.sv
// Timestamped trace event FIFO: up to three writes per cycle (overflow marker,
// ID/EX event, fetch event), first-word-fall-through read, saturating drop count.
module ibex_trace_event_buffer
    import ibex_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_ready,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_pc,
    input  logic [31:0]     fetch_insn,
    input  logic            idex_executing,
    input  logic            idex_done,
    input  logic [31:0]     idex_pc,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [2:0]      ev_type,
    output logic [TS_W-1:0] ev_ts,
    output logic [31:0]     ev_pc,
    output logic [31:0]     ev_data,
    output logic [15:0]     drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic      idex_vld, fetch_vld;
    trace_ev_t idex_ev, fetch_ev;

    ibex_trace_classify u_classify (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_ready    (fetch_ready),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_insn     (fetch_insn),
        .idex_executing (idex_executing),
        .idex_done      (idex_done),
        .idex_pc        (idex_pc),
        .idex_ev_valid  (idex_vld),
        .idex_ev        (idex_ev),
        .fetch_ev_valid (fetch_vld),
        .fetch_ev       (fetch_ev)
    );

    logic unused_cls_ts;
    assign unused_cls_ts = ^{idex_ev.ts, fetch_ev.ts};

    logic [2:0]      mem_type [DEPTH];
    logic [TS_W-1:0] mem_ts   [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];
    logic [31:0]     mem_data [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, free;
    logic [TS_W-1:0]  ts_q;
    logic             ovf_pending, ovf_pending_next;
    logic [15:0]      drop_next;
    logic [16:0]      drop_sum;
    logic             ovf_wr, pop;
    logic [1:0]       n_wr, n_drop;
    logic [2:0]       wr_en;
    logic [2:0]       wr_type [3];
    logic [31:0]      wr_pc   [3];
    logic [31:0]      wr_data [3];

    assign ev_valid = (count != '0);
    assign pop      = ev_valid && ev_ready;
    // Free space is taken at cycle start, so a same-cycle pop never makes room.
    assign free     = CNT_W'(DEPTH) - count;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            wr_type[k] = '0;
            wr_pc[k]   = '0;
            wr_data[k] = '0;
        end
        wr_en  = '0;
        n_wr   = '0;
        n_drop = '0;
        ovf_wr = ovf_pending && (free != '0);
        if (ovf_wr) begin
            wr_en[0]   = 1'b1;
            wr_type[0] = EV_OVF;
            n_wr       = 2'd1;
        end
        if (idex_vld) begin
            if (CNT_W'(n_wr) < free) begin
                wr_en[n_wr]   = 1'b1;
                wr_type[n_wr] = idex_ev.ev_type;
                wr_pc[n_wr]   = idex_ev.pc;
                wr_data[n_wr] = idex_ev.data;
                n_wr          = n_wr + 2'd1;
            end else begin
                n_drop = n_drop + 2'd1;
            end
        end
        if (fetch_vld) begin
            if (CNT_W'(n_wr) < free) begin
                wr_en[n_wr]   = 1'b1;
                wr_type[n_wr] = fetch_ev.ev_type;
                wr_pc[n_wr]   = fetch_ev.pc;
                wr_data[n_wr] = fetch_ev.data;
                n_wr          = n_wr + 2'd1;
            end else begin
                n_drop = n_drop + 2'd1;
            end
        end
        drop_sum  = {1'b0, drop_count} + 17'(n_drop);
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        // The marker reports the count including drops from this same cycle.
        if (ovf_wr) begin
            wr_data[0] = {16'b0, drop_next};
        end
        if (n_drop != '0) begin
            ovf_pending_next = 1'b1;
        end else if (ovf_wr) begin
            ovf_pending_next = 1'b0;
        end else begin
            ovf_pending_next = ovf_pending;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ts_q        <= '0;
            ovf_pending <= 1'b0;
            drop_count  <= '0;
        end else begin
            wr_ptr      <= wr_ptr + PTR_W'(n_wr);
            rd_ptr      <= rd_ptr + PTR_W'(pop);
            count       <= count + CNT_W'(n_wr) - CNT_W'(pop);
            ts_q        <= ts_q + TS_W'(1);
            ovf_pending <= ovf_pending_next;
            drop_count  <= drop_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wr_en[k]) begin
                mem_type[wr_ptr + PTR_W'(k)] <= wr_type[k];
                mem_ts  [wr_ptr + PTR_W'(k)] <= ts_q;
                mem_pc  [wr_ptr + PTR_W'(k)] <= wr_pc[k];
                mem_data[wr_ptr + PTR_W'(k)] <= wr_data[k];
            end
        end
    end

    assign ev_type = ev_valid ? mem_type[rd_ptr] : '0;
    assign ev_ts   = ev_valid ? mem_ts[rd_ptr]   : '0;
    assign ev_pc   = ev_valid ? mem_pc[rd_ptr]   : '0;
    assign ev_data = ev_valid ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_ibex_trace_event_buffer.sv
// Scoreboard bench: a cycle model pushes expected events, a monitor checks
// every handshake on the event port; directed scenarios plus random traffic.
module tb_ibex_trace_event_buffer;

    localparam int DEPTH = 8;
    localparam int TS_W  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            fetch_ready = 1'b0, fetch_valid = 1'b0;
    logic [31:0]     fetch_pc = '0, fetch_insn = '0;
    logic            idex_executing = 1'b0, idex_done = 1'b0;
    logic [31:0]     idex_pc = '0;
    logic            ev_valid, ev_ready = 1'b0;
    logic [2:0]      ev_type;
    logic [TS_W-1:0] ev_ts;
    logic [31:0]     ev_pc, ev_data;
    logic [15:0]     drop_count;

    ibex_trace_event_buffer #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc), .fetch_insn(fetch_insn),
        .idex_executing(idex_executing), .idex_done(idex_done), .idex_pc(idex_pc),
        .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_type(ev_type), .ev_ts(ev_ts), .ev_pc(ev_pc), .ev_data(ev_data),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] ts;
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   m_occ = 0, m_drop = 0, m_ts = 0;
    bit   m_ovf = 0, p_rdy = 0, p_vld = 0, p_exec = 0, p_done = 0;
    bit   ovf_seen = 0;
    int   last_ovf_data = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the buffer should contain after each coming edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_outputs", {ev_valid, ev_type, ev_ts, ev_pc, ev_data, drop_count}, '0);
            exp_q.delete();
            m_occ = 0; m_drop = 0; m_ts = 0; m_ovf = 0;
            p_rdy = 0; p_vld = 0; p_exec = 0; p_done = 0;
        end else begin
            int   idt, fdt, free, slots, drops, nw;
            bit   ovfw, pop, mult, put_id, put_f;
            exp_t e;
            chk("ev_valid", ev_valid, m_occ != 0);
            chk("drop_count", drop_count, m_drop);
            if (!ev_valid) chk("idle_zero", {ev_type, ev_ts, ev_pc, ev_data}, '0);

            mult = p_exec && !p_done;
            idt = -1;
            if (idex_executing && idex_done) idt = mult ? 5 : 3;
            else if (idex_executing && !mult) idt = 4;
            fdt = -1;
            if (fetch_ready && fetch_valid) fdt = (p_rdy && !p_vld) ? 2 : 0;
            else if (fetch_ready && (!p_rdy || p_vld)) fdt = 1;

            free  = DEPTH - m_occ;
            pop   = (m_occ != 0) && ev_ready;
            slots = free;
            drops = 0;
            ovfw  = m_ovf && free > 0;
            if (ovfw) slots--;
            put_id = 0; put_f = 0;
            if (idt >= 0) begin if (slots > 0) begin put_id = 1; slots--; end else drops++; end
            if (fdt >= 0) begin if (slots > 0) begin put_f = 1; slots--; end else drops++; end
            m_drop = (m_drop + drops > 65535) ? 65535 : m_drop + drops;
            nw = 0;
            if (ovfw) begin
                e = '{t: 3'd7, ts: m_ts[15:0], pc: 32'h0, data: m_drop}; exp_q.push_back(e); nw++;
            end
            if (put_id) begin
                e = '{t: idt[2:0], ts: m_ts[15:0], pc: idex_pc, data: 32'h0}; exp_q.push_back(e); nw++;
            end
            if (put_f) begin
                e.t = fdt[2:0]; e.ts = m_ts[15:0];
                e.pc   = (fdt == 1) ? 32'h0 : fetch_pc;
                e.data = (fdt == 1) ? 32'h0 : fetch_insn;
                exp_q.push_back(e); nw++;
            end
            if (drops > 0) m_ovf = 1; else if (ovfw) m_ovf = 0;
            m_occ = m_occ + nw - int'(pop);
            p_rdy = fetch_ready; p_vld = fetch_valid; p_exec = idex_executing; p_done = idex_done;
            m_ts = (m_ts + 1) % 65536;
        end
    end

    // Monitor: compare the presented head against the scoreboard, pop on handshake.
    always @(negedge clk) begin
        if (rst_n && ev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", ev_valid, 1'b0);
            end else begin
                chk("ev_type", ev_type, exp_q[0].t);
                chk("ev_ts", ev_ts, exp_q[0].ts);
                chk("ev_pc", ev_pc, exp_q[0].pc);
                chk("ev_data", ev_data, exp_q[0].data);
                if (ev_ready) begin
                    if (exp_q[0].t == 3'd7) begin ovf_seen = 1; last_ovf_data = int'(ev_data); end
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        fetch_ready = 0; fetch_valid = 0; idex_executing = 0; idex_done = 0; ev_ready = 1;
        cyc(n);
    endtask

    initial begin
        cyc(3);
        rst_n = 1;
        // single fetch straight out of reset
        fetch_ready = 1; fetch_valid = 1; fetch_pc = 32'h80; fetch_insn = 32'h13;
        cyc(1);
        chk("single_if", {ev_valid, ev_type, ev_ts, ev_pc, ev_data},
            {1'b1, 3'd0, 16'd0, 32'h80, 32'h13});
        idle(4);
        // multicycle fetch
        ev_ready = 0; fetch_ready = 1; fetch_valid = 0; fetch_pc = 32'h84; fetch_insn = 32'h00a00093;
        cyc(3);
        fetch_valid = 1;
        cyc(1);
        fetch_ready = 0; fetch_valid = 0;
        cyc(1);
        chk("mc_fetch_occ", {ev_valid, ev_type}, {1'b1, 3'd1});
        idle(4);
        // multicycle execute
        idex_executing = 1; idex_done = 0; idex_pc = 32'h100;
        cyc(2);
        idex_done = 1;
        cyc(1);
        idle(4);
        // ID/EX and fetch events in the same cycle
        ev_ready = 0; idex_executing = 1; idex_done = 1; idex_pc = 32'h200;
        fetch_ready = 1; fetch_valid = 1; fetch_pc = 32'h204; fetch_insn = 32'h33;
        cyc(1);
        idex_executing = 0; idex_done = 0; fetch_ready = 0; fetch_valid = 0;
        chk("dual_head", {ev_valid, ev_type, ev_pc}, {1'b1, 3'd3, 32'h200});
        idle(4);
        // overflow: ten fetches into eight slots
        ev_ready = 0; fetch_ready = 1; fetch_valid = 1;
        for (int i = 0; i < 10; i++) begin
            fetch_pc = 32'h1000 + 4 * i; fetch_insn = 32'hA000 + i;
            cyc(1);
        end
        fetch_ready = 0; fetch_valid = 0;
        cyc(2);
        chk("ovf_drop_count", drop_count, 16'd2);
        ev_ready = 1;
        cyc(15);
        chk("ovf_marker", {ovf_seen, 32'(last_ovf_data)}, {1'b1, 32'd2});
        // reset with events buffered
        ev_ready = 0; fetch_ready = 1; fetch_valid = 1;
        for (int i = 0; i < 5; i++) begin
            fetch_pc = 32'h2000 + 4 * i; cyc(1);
        end
        fetch_ready = 0; fetch_valid = 0;
        cyc(1);
        chk("pre_reset_valid", ev_valid, 1'b1);
        rst_n = 0;
        #1;
        chk("mid_reset", {ev_valid, drop_count}, 17'd0);
        cyc(2);
        rst_n = 1;
        fetch_ready = 1; fetch_valid = 1; fetch_pc = 32'h3000; fetch_insn = 32'h77;
        cyc(1);
        chk("ts_restart", {ev_valid, ev_ts, ev_pc}, {1'b1, 16'd0, 32'h3000});
        idle(4);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            fetch_ready    = ($urandom_range(0, 3) != 0);
            fetch_valid    = $urandom_range(0, 1);
            fetch_pc       = $urandom;
            fetch_insn     = $urandom;
            idex_executing = ($urandom_range(0, 3) != 0);
            idex_done      = $urandom_range(0, 1);
            idex_pc        = $urandom;
            ev_ready       = (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        idle(30);
        chk("drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
